code_fetch_buffer: RTL and testbench

- Downstream consumer of the code BRAM's wide read port.
- Accepts instruction-fetch requests by program counter (PC) from a regex core.
- Maps each PC to a 64-bit BRAM line and issues the line read.
- Holds the last fetched line in a one-line buffer so sequential PCs hit without a BRAM access, and returns one 16-bit instruction per request over a valid/ready handshake.

---
 rtl/code_fetch_pkg.sv | 27 ++
 rtl/code_fetch_buffer_sat_counter.sv | 20 ++
 rtl/code_fetch_buffer.sv | 142 ++++++++++++++
 tb/tb_code_fetch_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/code_fetch_pkg.sv
// Shared types, default widths and the lane extraction helper for the code fetch buffer.
// Default geometry: 16-bit instructions, four per 64-bit BRAM line, 512 lines.
package code_fetch_pkg;

  localparam int DEF_INSTR_WIDTH     = 16;
  localparam int DEF_LINE_WIDTH      = 64;
  localparam int DEF_LINE_ADDR_WIDTH = 9;
  localparam int DEF_CNT_WIDTH       = 32;
  localparam int DEF_LANES           = DEF_LINE_WIDTH / DEF_INSTR_WIDTH;
  localparam int DEF_LANE_BITS       = $clog2(DEF_LANES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    RESP
  } fetch_state_t;

  // Lane 0 occupies the least significant bits of the line.
  function automatic logic [DEF_INSTR_WIDTH-1:0] lane_select(
    input logic [DEF_LINE_WIDTH-1:0] line,
    input logic [DEF_LANE_BITS-1:0]  lane
  );
    return line[lane*DEF_INSTR_WIDTH +: DEF_INSTR_WIDTH];
  endfunction

endpackage

// File: rtl/code_fetch_buffer_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// One cycle from inc to updated count; no backpressure.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/code_fetch_buffer.sv
// One-line instruction buffer in front of the code BRAM; hits answer 1 cycle after accept, misses 3.
// One request in flight; response holds until resp_ready, and no request is taken until it drains.
module code_fetch_buffer
  import code_fetch_pkg::*;
#(
  parameter  int INSTR_WIDTH     = DEF_INSTR_WIDTH,
  parameter  int LINE_WIDTH      = DEF_LINE_WIDTH,
  parameter  int LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH,
  parameter  int CNT_WIDTH       = DEF_CNT_WIDTH,
  localparam int LANES           = LINE_WIDTH / INSTR_WIDTH,
  localparam int LANE_BITS       = $clog2(LANES),
  localparam int PC_WIDTH        = LINE_ADDR_WIDTH + LANE_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [PC_WIDTH-1:0]        req_pc,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [INSTR_WIDTH-1:0]     resp_instr,
  input  logic                       invalidate,
  output logic                       bram_r_valid,
  output logic [LINE_ADDR_WIDTH-1:0] bram_r_addr,
  input  logic [LINE_WIDTH-1:0]      bram_r_data,
  output logic [CNT_WIDTH-1:0]       stat_hits,
  output logic [CNT_WIDTH-1:0]       stat_misses
);

  fetch_state_t               state;
  logic [LINE_WIDTH-1:0]      line_buf;
  logic [LINE_ADDR_WIDTH-1:0] tag;
  logic                       line_valid;
  logic                       stale;
  logic [LINE_ADDR_WIDTH-1:0] line_q;
  logic [LANE_BITS-1:0]       lane_q;

  logic [LINE_ADDR_WIDTH-1:0] req_line;
  logic [LANE_BITS-1:0]       req_lane;
  logic                       accept;
  logic                       hit;
  logic [LINE_WIDTH-1:0]      sel_line;
  logic [LANE_BITS-1:0]       sel_lane;
  logic [INSTR_WIDTH-1:0]     sel_instr;

  assign req_line  = req_pc[PC_WIDTH-1:LANE_BITS];
  assign req_lane  = req_pc[LANE_BITS-1:0];
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  // An invalidate on the accept edge must not be overtaken by the old tag.
  assign hit       = line_valid && (tag == req_line) && !invalidate;

  // In WAIT the instruction comes straight from the BRAM data being captured.
  assign sel_line = (state == WAIT) ? bram_r_data : line_buf;
  assign sel_lane = (state == WAIT) ? lane_q : req_lane;

  if (INSTR_WIDTH == DEF_INSTR_WIDTH && LINE_WIDTH == DEF_LINE_WIDTH) begin : g_pkg_sel
    assign sel_instr = lane_select(sel_line, sel_lane);
  end else begin : g_gen_sel
    assign sel_instr = sel_line[sel_lane*INSTR_WIDTH +: INSTR_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      resp_instr   <= '0;
      bram_r_valid <= 1'b0;
      bram_r_addr  <= '0;
      line_buf     <= '0;
      tag          <= '0;
      line_valid   <= 1'b0;
      stale        <= 1'b0;
      line_q       <= '0;
      lane_q       <= '0;
    end else begin
      bram_r_valid <= 1'b0;
      if (invalidate) begin
        line_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            line_q <= req_line;
            lane_q <= req_lane;
            if (hit) begin
              resp_instr <= sel_instr;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              bram_r_valid <= 1'b1;
              bram_r_addr  <= req_line;
              state        <= FETCH;
            end
          end
        end
        FETCH: begin
          if (invalidate) begin
            stale <= 1'b1;
          end
          state <= WAIT;
        end
        WAIT: begin
          line_buf <= bram_r_data;
          // Data read before a rewrite is still returned, but never cached.
          if (invalidate) begin
            stale <= 1'b1;
          end else if (!stale) begin
            tag        <= line_q;
            line_valid <= 1'b1;
          end
          resp_instr <= sel_instr;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            stale      <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && hit),
    .count (stat_hits)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && !hit),
    .count (stat_misses)
  );

endmodule

// File: tb/tb_code_fetch_buffer.sv
// Directed and random fetch sequences against a line-level cache model of the fetch buffer.
// A second instance with 2-bit counters shares all stimulus to observe counter saturation.
module tb_code_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [10:0] req_pc;
  logic        resp_ready;
  logic        invalidate;
  logic [63:0] bram_r_data = '0;

  logic        req_ready, resp_valid, bram_r_valid;
  logic [15:0] resp_instr;
  logic [8:0]  bram_r_addr;
  logic [31:0] stat_hits, stat_misses;

  logic        s_req_ready, s_resp_valid, s_bram_r_valid;
  logic [15:0] s_resp_instr;
  logic [8:0]  s_bram_r_addr;
  logic [1:0]  s_hits, s_misses;

  logic [63:0] mem [512];

  int vectors = 0;
  int fails   = 0;

  // Reference state: which line (if any) the buffer may legally serve, plus counts.
  bit m_valid = 0;
  int m_line  = 0;
  int m_hits  = 0;
  int m_misses = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_r_valid) bram_r_data <= mem[bram_r_addr];
  end

  code_fetch_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pc       (req_pc),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_instr   (resp_instr),
    .invalidate   (invalidate),
    .bram_r_valid (bram_r_valid),
    .bram_r_addr  (bram_r_addr),
    .bram_r_data  (bram_r_data),
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses)
  );

  code_fetch_buffer #(.CNT_WIDTH(2)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (s_req_ready),
    .req_pc       (req_pc),
    .resp_valid   (s_resp_valid),
    .resp_ready   (resp_ready),
    .resp_instr   (s_resp_instr),
    .invalidate   (invalidate),
    .bram_r_valid (s_bram_r_valid),
    .bram_r_addr  (s_bram_r_addr),
    .bram_r_data  (bram_r_data),
    .stat_hits    (s_hits),
    .stat_misses  (s_misses)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check_stats();
    check("stat_hits", stat_hits, 64'(m_hits));
    check("stat_misses", stat_misses, 64'(m_misses));
    check("sat_hits", s_hits, 64'(sat3(m_hits)));
    check("sat_misses", s_misses, 64'(sat3(m_misses)));
  endtask

  task automatic pulse_invalidate();
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    m_valid = 0;
  endtask

  // inv_at: cycle (0 = accept cycle) in which invalidate is pulsed, -1 for none.
  task automatic do_req(input int pc, input int inv_at, input int hold);
    int line, lane, cyc, nrd, inv;
    bit would_hit, exp_hit;
    logic [15:0] exp_instr;
    line = pc >> 2;
    lane = pc & 3;
    inv = inv_at;
    would_hit = m_valid && (m_line == line);
    if (would_hit && inv == 2) inv = -1;
    exp_hit = would_hit && (inv != 0);
    exp_instr = 16'(mem[line] >> (16 * lane));

    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_pc     = 11'(pc);
    resp_ready = 1'b0;
    invalidate = (inv == 0);
    cyc = 0;
    nrd = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      req_valid  = 1'b0;
      invalidate = (inv == cyc);
      if (bram_r_valid) begin
        nrd++;
        check("bram_addr", bram_r_addr, 64'(line));
      end
    end while (!resp_valid && cyc < 12);

    if (exp_hit) begin
      m_hits++;
      if (inv >= 1) m_valid = 0;
    end else begin
      m_misses++;
      m_line  = line;
      m_valid = !(inv == 1 || inv == 2);
    end

    check("latency", 64'(cyc), exp_hit ? 64'd1 : 64'd3);
    check("bram_reads", 64'(nrd), exp_hit ? 64'd0 : 64'd1);
    check("resp_valid", resp_valid, 1);
    check("resp_instr", resp_instr, exp_instr);
    check_stats();

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      invalidate = 1'b0;
      check("hold_valid", resp_valid, 1);
      check("hold_instr", resp_instr, exp_instr);
      check("hold_req_ready", req_ready, 0);
      check("hold_no_read", bram_r_valid, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    resp_ready = 1'b0;
    check("resp_drained", resp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  initial begin
    int pc, r, inv_at, waited;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    mem[1] = 64'h4444_3333_2222_1111;
    rst = 1'b1;
    req_valid = 1'b0;
    req_pc = '0;
    resp_ready = 1'b0;
    invalidate = 1'b0;

    #2 rst = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_instr", resp_instr, 0);
    check("rst_bram_valid", bram_r_valid, 0);
    check("rst_bram_addr", bram_r_addr, 0);
    check_stats();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    do_req(5, -1, 0);      // cold miss, line 1 lane 1
    do_req(7, -1, 0);      // hit, lane 3
    do_req(6, -1, 5);      // hit under backpressure
    pulse_invalidate();
    do_req(4, 2, 0);       // miss with rewrite during WAIT: returned, not cached
    do_req(6, -1, 0);      // must miss again
    do_req(2047, -1, 0);   // top line, top lane
    do_req(0, -1, 0);      // wrap to line 0
    do_req(1, 0, 0);       // invalidate on accept forces a miss

    // Reset in the middle of a response.
    req_valid = 1'b1;
    req_pc = 11'd3;
    waited = 0;
    do begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      waited++;
    end while (!resp_valid && waited < 12);
    check("pre_reset_resp_valid", resp_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_instr", resp_instr, 0);
    check("mid_rst_bram_valid", bram_r_valid, 0);
    check("mid_rst_bram_addr", bram_r_addr, 0);
    m_valid = 0;
    m_hits = 0;
    m_misses = 0;
    check_stats();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", req_ready, 1);
    check_stats();
    do_req(3, -1, 0);      // buffer cleared by reset: miss

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        mem[$urandom_range(0, 511)] = {$urandom, $urandom};
        pulse_invalidate();
      end
      if (m_valid && $urandom_range(0, 1) == 1)
        pc = m_line * 4 + $urandom_range(0, 3);
      else
        pc = $urandom_range(0, 2047);
      r = $urandom_range(0, 7);
      inv_at = (r < 5) ? -1 : r - 5;
      do_req(pc, inv_at, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
